// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline control blocks: the scoreboard entry layout
// and the forwarding-select encoding.
package mips_pipe_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  is_load;
  } sb_entry_t;

endpackage

// File: rtl/pipe_operand_match.sv
// Finds the youngest (lowest-index) scoreboard stage writing one source register.
// Register $0 never matches.
module pipe_operand_match #(
  parameter  int DEPTH      = 3,
  parameter  int REG_ADDR_W = 5,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic [REG_ADDR_W-1:0]       src_i,
  input  logic                        used_i,
  input  logic [DEPTH-1:0]            valid_i,
  input  logic [DEPTH*REG_ADDR_W-1:0] dest_i,
  output logic                        hit_o,
  output logic [IDX_W-1:0]            idx_o
);

  // Scan oldest to youngest so the last hit written is the youngest.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (used_i && (src_i != '0) && valid_i[i-1] &&
          (dest_i[(i-1)*REG_ADDR_W +: REG_ADDR_W] == src_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i-1);
      end
    end
  end

endmodule

// File: rtl/mips_hazard_unit.sv
// Hazard detection and EX forwarding control beside the ID stage.
// Define HAZARD_FORWARD_EN for forwarding; otherwise a pure interlock.
module mips_hazard_unit
  import mips_pipe_pkg::*;
#(
  parameter  int REG_ADDR_W   = 5,
  parameter  int DEPTH        = 3,
  parameter  int BRANCH_STAGE = 1,
  parameter  int CNT_W        = 32,
  localparam int FWD_W        = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_reg_write,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  pc_hold,
  output logic                  if_id_hold,
  output logic                  id_ex_bubble,
  output logic                  if_id_flush,
  output logic [FWD_W-1:0]      ex_fwd_a,
  output logic [FWD_W-1:0]      ex_fwd_b,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [DEPTH-1:0]      sb_valid
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int unsigned BS_U  = BRANCH_STAGE;

  sb_entry_t sb_q [DEPTH];
  sb_entry_t sb_d [DEPTH];

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            loads;
  logic [DEPTH*REG_ADDR_W-1:0] dests;
  logic                        hit_a, hit_b;
  logic [IDX_W-1:0]            idx_a, idx_b;
  logic                        wait_a, wait_b, stall;
  logic [CNT_W-1:0]            stall_cycles_q, stall_cycles_d;

  always_comb begin
    vld   = '0;
    loads = '0;
    dests = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      vld[i]                             = sb_q[i].valid;
      loads[i]                           = sb_q[i].is_load;
      dests[i*REG_ADDR_W +: REG_ADDR_W]  = sb_q[i].dest;
    end
  end

  pipe_operand_match #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W)) u_match_rs (
    .src_i(id_rs), .used_i(id_uses_rs), .valid_i(vld), .dest_i(dests),
    .hit_o(hit_a), .idx_o(idx_a)
  );

  pipe_operand_match #(.DEPTH(DEPTH), .REG_ADDR_W(REG_ADDR_W)) u_match_rt (
    .src_i(id_rt), .used_i(id_uses_rt), .valid_i(vld), .dest_i(dests),
    .hit_o(hit_b), .idx_o(idx_b)
  );

`ifdef HAZARD_FORWARD_EN
  // Load still in EX has no data yet; the retiring stage cannot be read (no write-through).
  assign wait_a = hit_a & (((idx_a == '0) & loads[0]) | (idx_a == IDX_W'(DEPTH-1)));
  assign wait_b = hit_b & (((idx_b == '0) & loads[0]) | (idx_b == IDX_W'(DEPTH-1)));
`else
  assign wait_a = hit_a;
  assign wait_b = hit_b;
`endif

  assign stall        = id_valid & (wait_a | wait_b) & ~flush;
  assign pc_hold      = stall;
  assign if_id_hold   = stall;
  assign id_ex_bubble = stall | flush;
  assign if_id_flush  = flush;
  assign stall_cycles = stall_cycles_q;
  assign sb_valid     = vld;

  always_comb begin
    if (stall || flush) begin
      sb_d[0] = '0;
    end else begin
      sb_d[0].valid   = id_valid & id_reg_write & (id_dest != '0);
      sb_d[0].dest    = id_dest;
      sb_d[0].is_load = id_mem_read;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sb_d[i] = (flush && (i <= BS_U)) ? '0 : sb_q[i-1];
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) sb_q[i] <= sb_d[i];
      stall_cycles_q <= stall_cycles_d;
    end
  end

`ifdef HAZARD_FORWARD_EN
  logic [FWD_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Select k means the output register of stage k-1.
  always_comb begin
    fwd_a_d = FWD_W'(FWD_REGFILE);
    fwd_b_d = FWD_W'(FWD_REGFILE);
    if (id_valid && !stall && !flush) begin
      if (hit_a) fwd_a_d = FWD_W'(idx_a) + FWD_W'(1);
      if (hit_b) fwd_b_d = FWD_W'(idx_b) + FWD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign ex_fwd_a = fwd_a_q;
  assign ex_fwd_b = fwd_b_q;
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx_a, idx_b, loads};
  assign ex_fwd_a   = FWD_W'(FWD_REGFILE);
  assign ex_fwd_b   = FWD_W'(FWD_REGFILE);
`endif

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Bench for mips_hazard_unit: directed vector table, reset-mid-stall sequence,
// then random traffic against an instruction-history model.
module tb_mips_hazard_unit;

  localparam int RW    = 5;
  localparam int DEPTH = 3;
  localparam int BS    = 1;
  localparam int CNT_W = 32;
  localparam int FWD_W = $clog2(DEPTH+1);
`ifdef HAZARD_FORWARD_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [RW-1:0] id_rs, id_rt, id_dest;
  logic pc_hold, if_id_hold, id_ex_bubble, if_id_flush;
  logic [FWD_W-1:0] ex_fwd_a, ex_fwd_b;
  logic [CNT_W-1:0] stall_cycles;
  logic [DEPTH-1:0] sb_valid;

  always #5 clk = ~clk;

  mips_hazard_unit #(.REG_ADDR_W(RW), .DEPTH(DEPTH), .BRANCH_STAGE(BS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
    .id_dest(id_dest), .id_mem_read(id_mem_read), .flush(flush),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
    .stall_cycles(stall_cycles), .sb_valid(sb_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction history: index 0 is the instruction issued most recently.
  typedef struct { bit v; int d; bit ld; } ment_t;
  ment_t  hist[$];
  int     m_fa, m_fb;
  longint m_cnt;

  function automatic int youngest(input bit used, input int src);
    if (!used || src == 0) return -1;
    foreach (hist[i]) if (hist[i].v && hist[i].d == src) return i;
    return -1;
  endfunction

  function automatic bit needs_stall(input int p);
    if (p < 0) return 1'b0;
    if (!FW) return 1'b1;
    return (p == 0 && hist[0].ld) || (p == DEPTH-1);
  endfunction

  function automatic void model_reset();
    ment_t e;
    e.v = 0; e.d = 0; e.ld = 0;
    hist = {};
    for (int i = 0; i < DEPTH; i++) hist.push_back(e);
    m_fa = 0; m_fb = 0; m_cnt = 0;
  endfunction

  typedef struct {
    bit r;
    bit v; int rs; int rt; bit urs; bit urt; bit rw; int dest; bit mr; bit fl;
    bit hold_fw; bit hold_il; int fa; int fb;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, int rs, int rt, bit urs, bit urt, bit rw, int dest,
                              bit mr, bit fl, bit hf, bit hi, int fa, int fb);
    vec_t x;
    x.r = r; x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.rw = rw;
    x.dest = dest; x.mr = mr; x.fl = fl; x.hold_fw = hf; x.hold_il = hi; x.fa = fa; x.fb = fb;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs = RW'(x.rs); id_rt = RW'(x.rt);
    id_uses_rs = x.urs; id_uses_rt = x.urt; id_reg_write = x.rw;
    id_dest = RW'(x.dest); id_mem_read = x.mr; flush = x.fl;
  endtask

  task automatic step(input vec_t x, input string tag, input bit use_tab);
    int pa, pb;
    bit st;
    ment_t ne;
    logic [DEPTH-1:0] esb;
    drive(x);
    #2;
    pa = youngest(x.urs, x.rs);
    pb = youngest(x.urt, x.rt);
    st = x.v && (needs_stall(pa) || needs_stall(pb)) && !x.fl;
    for (int i = 0; i < DEPTH; i++) esb[i] = hist[i].v;
    chk($sformatf("%s.pc_hold", tag), pc_hold, st);
    chk($sformatf("%s.if_id_hold", tag), if_id_hold, st);
    chk($sformatf("%s.bubble", tag), id_ex_bubble, st | x.fl);
    chk($sformatf("%s.if_id_flush", tag), if_id_flush, x.fl);
    chk($sformatf("%s.fwd_a", tag), ex_fwd_a, m_fa);
    chk($sformatf("%s.fwd_b", tag), ex_fwd_b, m_fb);
    chk($sformatf("%s.stall_cycles", tag), stall_cycles, m_cnt);
    chk($sformatf("%s.sb_valid", tag), sb_valid, esb);
    if (use_tab) begin
      chk($sformatf("%s.tab_hold", tag), pc_hold, FW ? x.hold_fw : x.hold_il);
      chk($sformatf("%s.tab_fwd_a", tag), ex_fwd_a, FW ? x.fa : 0);
      chk($sformatf("%s.tab_fwd_b", tag), ex_fwd_b, FW ? x.fb : 0);
    end
    m_fa = (FW && x.v && !st && !x.fl && pa >= 0) ? pa + 1 : 0;
    m_fb = (FW && x.v && !st && !x.fl && pb >= 0) ? pb + 1 : 0;
    ne.v  = x.v && x.rw && (x.dest != 0) && !st && !x.fl;
    ne.d  = x.dest;
    ne.ld = x.mr;
    hist.push_front(ne);
    void'(hist.pop_back());
    if (x.fl) for (int k = 0; k <= BS; k++) hist[k].v = 1'b0;
    if (st && m_cnt != 64'hFFFF_FFFF) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle with the current ID inputs left in place.
  task automatic do_reset(input string tag);
    flush = 1'b0;
    rst = 1'b1;
    #1;
    chk($sformatf("%s.rst_pc_hold", tag), pc_hold, 0);
    chk($sformatf("%s.rst_bubble", tag), id_ex_bubble, 0);
    chk($sformatf("%s.rst_fwd_a", tag), ex_fwd_a, 0);
    chk($sformatf("%s.rst_fwd_b", tag), ex_fwd_b, 0);
    chk($sformatf("%s.rst_cnt", tag), stall_cycles, 0);
    chk($sformatf("%s.rst_sb_valid", tag), sb_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tab[$];
  vec_t nop;

  initial begin
    rst = 1'b1;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(nop);
    model_reset();

    // add $3 ; sub $5,$3,$1
    tab.push_back(mk(1, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 3, 1, 1, 1, 1, 5, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // lw $4 ; add $6,$4,$4
    tab.push_back(mk(1, 1, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 4, 4, 1, 1, 1, 6, 0, 0, 1, 1, 0, 0));
    tab.push_back(mk(0, 1, 4, 4, 1, 1, 1, 6, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
    // add $3 ; repeated use of $3 (distance grows to DEPTH)
    tab.push_back(mk(1, 1, 1, 2, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 3, 0, 1, 0, 1, 7, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 1, 3, 0, 1, 0, 1, 7, 0, 0, 0, 1, 1, 0));
    tab.push_back(mk(0, 1, 3, 0, 1, 0, 1, 7, 0, 0, 1, 1, 2, 0));
    tab.push_back(mk(0, 1, 3, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // add $0 ; use $0
    tab.push_back(mk(1, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 1, 1, 1, 8, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // lw $4 ; add $6,$4,$4 with flush in the stall cycle
    tab.push_back(mk(1, 1, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 4, 4, 1, 1, 1, 6, 0, 1, 0, 0, 0, 0));
    tab.push_back(mk(0, 1, 4, 4, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].r) do_reset($sformatf("vec%0d", i));
      step(tab[i], $sformatf("vec%0d", i), 1'b1);
    end

    // Reset pulsed while a load-use stall is being signalled.
    do_reset("mid");
    step(mk(0, 1, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0), "mid_lw", 1'b1);
    drive(mk(0, 1, 4, 4, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0));
    #2;
    chk("mid.stall_before_rst", pc_hold, 1);
    do_reset("mid");
    step(mk(0, 1, 4, 4, 1, 1, 1, 6, 0, 0, 0, 0, 0, 0), "mid_after", 1'b1);

    for (int n = 0; n < 600; n++) begin
      vec_t x;
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      x = mk(0, ($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
             0, 0, 0, 0);
      step(x, $sformatf("rnd%0d", n), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
